core_scheduler: RTL and testbench

CORE_SCHEDULER -- requirements
Module: core_scheduler

---
 rtl/core_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_core_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_scheduler.sv
// Dispatches tagged jobs to N inference cores and funnels their results,
// round-robin, through a single result register with a valid/ready handshake.
module core_scheduler #(
  parameter int N_CORES = 4,
  parameter int OUT_W   = 32,
  parameter int ID_W    = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [N_CORES-1:0]                            core_en,
  input  logic                                          job_valid,
  input  logic [ID_W-1:0]                               job_id,
  output logic                                          job_ready,
  output logic [N_CORES-1:0]                            core_start,
  output logic [N_CORES*ID_W-1:0]                       core_job_id,
  input  logic [N_CORES-1:0]                            core_done,
  input  logic [N_CORES*OUT_W-1:0]                      core_value,
  output logic                                          res_valid,
  input  logic                                          res_ready,
  output logic [ID_W-1:0]                               res_id,
  output logic [OUT_W-1:0]                              res_value,
  output logic [((N_CORES > 1) ? $clog2(N_CORES) : 1)-1:0] res_core,
  output logic                                          res_timeout,
  output logic [N_CORES-1:0]                            busy,
  output logic                                          idle,
  output logic [15:0]                                   timeout_count
);

  localparam int RC_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_FREE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_HOLD  = 2'd3
  } core_state_e;

  logic [N_CORES-1:0]       free_vec;
  logic [N_CORES-1:0]       hold_vec;
  logic [N_CORES-1:0]       disp_grant;
  logic [N_CORES-1:0]       to_evt;
  logic [N_CORES*ID_W-1:0]  id_all;
  logic [N_CORES*OUT_W-1:0] val_all;
  logic [N_CORES-1:0]       to_all;
  logic                     disp_found;
  logic                     job_accept;
  logic                     load_en;
  logic                     out_any;
  logic                     out_take;
  logic [RC_W-1:0]          out_idx;
  logic [RC_W-1:0]          rr_ptr_reg;
  logic [RC_W-1:0]          rr_ptr_next;
  logic [16:0]              to_sum;
  logic [15:0]              timeout_count_reg;
  logic [15:0]              timeout_count_next;
  logic                     res_valid_reg;
  logic [ID_W-1:0]          res_id_reg;
  logic [OUT_W-1:0]         res_value_reg;
  logic [RC_W-1:0]          res_core_reg;
  logic                     res_timeout_reg;

  // Dispatch only looks at registered core state, plus the enable mask.
  assign job_ready  = |(free_vec & core_en);
  assign job_accept = job_valid & job_ready;

  always_comb begin
    disp_grant = '0;
    disp_found = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      if (!disp_found && free_vec[i] && core_en[i]) begin
        disp_grant[i] = 1'b1;
        disp_found    = 1'b1;
      end
    end
  end

  // Round-robin search over HOLD cores starting at rr_ptr_reg.
  always_comb begin
    out_any = 1'b0;
    out_idx = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (!out_any && hold_vec[(int'(rr_ptr_reg) + i) % N_CORES]) begin
        out_any = 1'b1;
        out_idx = RC_W'((int'(rr_ptr_reg) + i) % N_CORES);
      end
    end
  end

  assign load_en  = !res_valid_reg || res_ready;
  assign out_take = load_en && out_any;

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (out_take) begin
      rr_ptr_next = (out_idx == RC_W'(N_CORES - 1)) ? '0 : out_idx + 1'b1;
    end
  end

  // Several cores may time out in the same cycle; add them all, then saturate.
  always_comb begin
    to_sum = {1'b0, timeout_count_reg};
    for (int i = 0; i < N_CORES; i++) begin
      to_sum = to_sum + 17'(to_evt[i]);
    end
    timeout_count_next = to_sum[16] ? 16'hFFFF : to_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_reg     <= 1'b0;
      res_id_reg        <= '0;
      res_value_reg     <= '0;
      res_core_reg      <= '0;
      res_timeout_reg   <= 1'b0;
      rr_ptr_reg        <= '0;
      timeout_count_reg <= '0;
    end else begin
      if (out_take) begin
        res_valid_reg   <= 1'b1;
        res_id_reg      <= id_all[out_idx*ID_W +: ID_W];
        res_value_reg   <= val_all[out_idx*OUT_W +: OUT_W];
        res_core_reg    <= out_idx;
        res_timeout_reg <= to_all[out_idx];
      end else if (res_valid_reg && res_ready) begin
        res_valid_reg <= 1'b0;
      end
      rr_ptr_reg        <= rr_ptr_next;
      timeout_count_reg <= timeout_count_next;
    end
  end

  assign res_valid     = res_valid_reg;
  assign res_id        = res_id_reg;
  assign res_value     = res_value_reg;
  assign res_core      = res_core_reg;
  assign res_timeout   = res_timeout_reg;
  assign timeout_count = timeout_count_reg;
  assign busy          = ~free_vec;
  assign idle          = (&free_vec) && !res_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_core
      core_state_e      state_reg;
      core_state_e      state_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [ID_W-1:0]  id_reg;
      logic [OUT_W-1:0] val_reg;
      logic             to_reg;
      logic             done_hit;
      logic             to_hit;
      logic             release_core;
      logic             is_free;
      logic             is_start;
      logic             is_hold;

      // cnt_reg is 0 only in the first RUN cycle, which masks done there.
      assign done_hit     = (state_reg == S_RUN) && (cnt_reg != '0) && core_done[gi];
      assign to_hit       = (TIMEOUT > 0) && (state_reg == S_RUN) && !done_hit &&
                            (cnt_reg == TO_LAST);
      assign release_core = out_take && (out_idx == RC_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= S_FREE;
        end else begin
          state_reg <= state_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        unique case (state_reg)
          S_FREE:  if (job_accept && disp_grant[gi]) state_next = S_START;
          S_START: state_next = S_RUN;
          S_RUN:   if (done_hit || to_hit) state_next = S_HOLD;
          S_HOLD:  if (release_core) state_next = S_FREE;
          default: state_next = S_FREE;
        endcase
      end

      always_comb begin
        is_free  = (state_reg == S_FREE);
        is_start = (state_reg == S_START);
        is_hold  = (state_reg == S_HOLD);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
          id_reg  <= '0;
          val_reg <= '0;
          to_reg  <= 1'b0;
        end else begin
          if (is_free && job_accept && disp_grant[gi]) begin
            id_reg <= job_id;
          end
          if (is_start) begin
            cnt_reg <= '0;
          end else if ((state_reg == S_RUN) && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          if (done_hit) begin
            val_reg <= core_value[gi*OUT_W +: OUT_W];
            to_reg  <= 1'b0;
          end else if (to_hit) begin
            val_reg <= '0;
            to_reg  <= 1'b1;
          end
        end
      end

      assign free_vec[gi]                   = is_free;
      assign hold_vec[gi]                   = is_hold;
      assign core_start[gi]                 = is_start;
      assign to_evt[gi]                     = to_hit;
      assign to_all[gi]                     = to_reg;
      assign core_job_id[gi*ID_W +: ID_W]   = id_reg;
      assign id_all[gi*ID_W +: ID_W]        = id_reg;
      assign val_all[gi*OUT_W +: OUT_W]     = val_reg;
    end
  endgenerate

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler (4 cores, TIMEOUT=16); checks are taken
// 1 time unit after each rising edge.
module tb_core_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  core_en;
  logic        job_valid;
  logic [7:0]  job_id;
  logic        job_ready;
  logic [3:0]  core_start;
  logic [31:0] core_job_id;
  logic [3:0]  core_done;
  logic [127:0] core_value;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_id;
  logic [31:0] res_value;
  logic [1:0]  res_core;
  logic        res_timeout;
  logic [3:0]  busy;
  logic        idle;
  logic [15:0] timeout_count;

  int total = 0;
  int bad   = 0;

  core_scheduler #(.N_CORES(4), .OUT_W(32), .ID_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .core_en(core_en), .job_valid(job_valid),
    .job_id(job_id), .job_ready(job_ready), .core_start(core_start),
    .core_job_id(core_job_id), .core_done(core_done), .core_value(core_value),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_value(res_value), .res_core(res_core), .res_timeout(res_timeout),
    .busy(busy), .idle(idle), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [1:0] core, input logic [7:0] id,
                         input logic [31:0] val, input logic to);
    chk({tag, "_valid"}, 64'(res_valid), 64'd1);
    chk({tag, "_core"}, 64'(res_core), 64'(core));
    chk({tag, "_id"}, 64'(res_id), 64'(id));
    chk({tag, "_value"}, 64'(res_value), 64'(val));
    chk({tag, "_timeout"}, 64'(res_timeout), 64'(to));
  endtask

  initial begin
    rst        = 1'b1;
    core_en    = 4'hF;
    job_valid  = 1'b0;
    job_id     = 8'h00;
    core_done  = 4'h0;
    core_value = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    res_ready  = 1'b0;
    tick();
    tick();

    // Reset state.
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_job_ready", 64'(job_ready), 64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_core_start", 64'(core_start), 64'h0);
    chk("rst_core_job_id", 64'(core_job_id), 64'h0);
    chk("rst_timeout_count", 64'(timeout_count), 64'h0);
    chk("rst_res_payload", {res_id, res_value, res_core, res_timeout}, 64'h0);
    rst = 1'b0;
    tick();

    // Four back-to-back jobs fill cores 0..3 in order.
    res_ready = 1'b1;
    job_valid = 1'b1;
    job_id    = 8'h10;
    tick();
    chk("s1_start0", 64'(core_start), 64'h1);
    chk("s1_ready_after1", 64'(job_ready), 64'd1);
    job_id = 8'h11;
    tick();
    chk("s1_start1", 64'(core_start), 64'h2);
    job_id = 8'h12;
    tick();
    chk("s1_start2", 64'(core_start), 64'h4);
    job_id = 8'h13;
    tick();
    chk("s1_start3", 64'(core_start), 64'h8);
    chk("s1_ready_full", 64'(job_ready), 64'd0);
    chk("s1_job_ids", 64'(core_job_id), 64'h13121110);
    job_valid = 1'b0;

    // Cores 1 and 3 done together: results 2 and 3 cycles later, core 1 first.
    tick();
    tick();
    core_done = 4'b1010;
    tick();
    core_done = 4'b0000;
    chk("s2_valid_d1", 64'(res_valid), 64'd0);
    chk("s2_busy_d1", 64'(busy), 64'hF);
    tick();
    chk_res("s2_first", 2'd1, 8'h11, 32'hBBBB0001, 1'b0);
    chk("s2_busy_d2", 64'(busy), 64'hD);
    tick();
    chk_res("s2_second", 2'd3, 8'h13, 32'hDDDD0003, 1'b0);
    chk("s2_busy_d3", 64'(busy), 64'h5);
    tick();
    chk("s2_drained", 64'(res_valid), 64'd0);

    // Core 2 finishes normally; core 0 never does and times out.
    core_done = 4'b0100;
    tick();
    core_done = 4'b0000;
    tick();
    chk_res("s3_core2", 2'd2, 8'h12, 32'hCCCC0002, 1'b0);
    tick();
    chk("s3_valid_gap", 64'(res_valid), 64'd0);
    repeat (4) tick();
    chk("s3_pre_to_count", 64'(timeout_count), 64'h0);
    chk("s3_pre_to_busy", 64'(busy), 64'h1);
    tick();
    chk("s3_to_count", 64'(timeout_count), 64'h1);
    chk("s3_to_valid_early", 64'(res_valid), 64'd0);
    tick();
    chk_res("s3_timeout", 2'd0, 8'h10, 32'h0, 1'b1);
    tick();
    chk("s3_idle", 64'(idle), 64'd1);

    // Enable mask 0101: jobs go to cores 0 and 2; core 0 still reports after its enable drops.
    core_en   = 4'b0101;
    job_valid = 1'b1;
    job_id    = 8'h20;
    tick();
    chk("s4_start0", 64'(core_start), 64'h1);
    job_id = 8'h21;
    tick();
    chk("s4_start2", 64'(core_start), 64'h4);
    chk("s4_ready_full", 64'(job_ready), 64'd0);
    job_valid = 1'b0;
    core_en   = 4'b0100;
    tick();
    core_done = 4'b0001;
    chk("s4_busy", 64'(busy), 64'h5);
    tick();
    core_done = 4'b0000;
    tick();
    chk_res("s4_core0", 2'd0, 8'h20, 32'hAAAA0000, 1'b0);
    chk("s4_ready_masked", 64'(job_ready), 64'd0);
    core_done = 4'b0100;
    tick();
    core_done = 4'b0000;
    chk("s4_valid_gap", 64'(res_valid), 64'd0);
    tick();
    chk_res("s4_core2", 2'd2, 8'h21, 32'hCCCC0002, 1'b0);
    tick();
    chk("s4_idle", 64'(idle), 64'd1);

    // Back-pressure: all four done while res_ready is low for 50 cycles.
    core_en   = 4'hF;
    res_ready = 1'b0;
    job_valid = 1'b1;
    job_id    = 8'h30;
    tick();
    chk("s5_start0", 64'(core_start), 64'h1);
    job_id = 8'h31;
    tick();
    job_id = 8'h32;
    tick();
    job_id = 8'h33;
    tick();
    job_valid = 1'b0;
    chk("s5_job_ids", 64'(core_job_id), 64'h33323130);
    tick();
    tick();
    core_done = 4'hF;
    tick();
    core_done = 4'h0;
    chk("s5_all_hold", 64'(busy), 64'hF);
    tick();
    chk_res("s5_first", 2'd3, 8'h33, 32'hDDDD0003, 1'b0);
    chk("s5_not_idle", 64'(idle), 64'd0);
    repeat (50) tick();
    chk_res("s5_stalled", 2'd3, 8'h33, 32'hDDDD0003, 1'b0);
    chk("s5_stall_busy", 64'(busy), 64'h7);
    chk("s5_stall_ready", 64'(job_ready), 64'd1);
    res_ready = 1'b1;
    tick();
    chk_res("s5_r0", 2'd0, 8'h30, 32'hAAAA0000, 1'b0);
    tick();
    chk_res("s5_r1", 2'd1, 8'h31, 32'hBBBB0001, 1'b0);
    tick();
    chk_res("s5_r2", 2'd2, 8'h32, 32'hCCCC0002, 1'b0);
    tick();
    chk("s5_drained", 64'(res_valid), 64'd0);
    chk("s5_idle", 64'(idle), 64'd1);
    chk("s5_to_count", 64'(timeout_count), 64'h1);

    // Reset in the middle of RUN with done asserted at the same edge.
    job_valid = 1'b1;
    job_id    = 8'h40;
    tick();
    chk("s6_start0", 64'(core_start), 64'h1);
    job_id = 8'h41;
    tick();
    chk("s6_start1", 64'(core_start), 64'h2);
    job_valid = 1'b0;
    tick();
    core_done = 4'b0011;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_busy", 64'(busy), 64'h0);
    chk("s6_idle", 64'(idle), 64'd1);
    chk("s6_res_valid", 64'(res_valid), 64'd0);
    chk("s6_core_start", 64'(core_start), 64'h0);
    chk("s6_core_job_id", 64'(core_job_id), 64'h0);
    chk("s6_to_count", 64'(timeout_count), 64'h0);
    chk("s6_job_ready", 64'(job_ready), 64'd1);
    tick();
    chk("s6_stale_done_busy", 64'(busy), 64'h0);
    chk("s6_stale_done_valid", 64'(res_valid), 64'd0);
    core_done = 4'b0000;
    job_valid = 1'b1;
    job_id    = 8'h50;
    tick();
    chk("s6_new_start", 64'(core_start), 64'h1);
    chk("s6_new_id", 64'(core_job_id), 64'h00000050);
    job_valid = 1'b0;
    tick();
    tick();
    core_done = 4'b0001;
    tick();
    core_done = 4'b0000;
    tick();
    chk_res("s6_result", 2'd0, 8'h50, 32'hAAAA0000, 1'b0);
    tick();
    chk("s6_final_idle", 64'(idle), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
